// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Decode-stage hazard, forwarding and flush controller for the in-order
//   pipeline. A per-register scoreboard tracks every in-flight write, with
//   the producer's own result latency and its current downstream stage (age).
//
//   Optional feature macro: HAZARD_PERF_EN enables the saturating 16-bit
//   stall-cycle counter; without it stall_cycles is tied to zero.
//
//   Ports
//     clk, rst_n           clock (rising), async active-low reset
//     id_valid             ID holds an instruction
//     id_rs/id_rt(+_used)  source registers and their read enables
//     id_wreg, id_wdst     destination write enable / register
//     id_lat               stage at which the result becomes forwardable
//     id_branch_taken      branch/jump resolved taken in ID
//     ex_busy              downstream structural stall, freezes pipeline
//     stall, issue         hold IF/ID, ID instruction advances
//     fwda, fwdb           0 = register file, k = result of stage k
//     redirect             taken branch accepted, PC loads target
//     cancel_next          squash the instruction now in IF/ID
//     stall_cycles         stall performance counter

// One scoreboard entry: pending flag, current stage and forwardable stage.
module hazard_sb_entry #(
  parameter int FWD_STAGES = 3,
  parameter int FSEL_W     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold_i,
  input  logic              ins_i,
  input  logic [FSEL_W-1:0] ins_lat_i,
  output logic              pend_o,
  output logic [FSEL_W-1:0] age_o,
  output logic [FSEL_W-1:0] lat_o
);
  localparam logic [FSEL_W-1:0] LAST = FSEL_W'(FWD_STAGES);

  logic              pend_q, pend_d;
  logic [FSEL_W-1:0] age_q, age_d, lat_q, lat_d;

  always_comb begin
    pend_d = pend_q;
    age_d  = age_q;
    lat_d  = lat_q;
    if (!hold_i && pend_q) begin
      // leaving the last forward stage means the value is in the register file
      if (age_q == LAST) pend_d = 1'b0;
      else               age_d  = age_q + 1'b1;
    end
    // a new producer replaces whatever was tracked (youngest writer wins)
    if (ins_i) begin
      pend_d = 1'b1;
      age_d  = FSEL_W'(1);
      lat_d  = ins_lat_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      age_q  <= '0;
      lat_q  <= '0;
    end else begin
      pend_q <= pend_d;
      age_q  <= age_d;
      lat_q  <= lat_d;
    end
  end

  assign pend_o = pend_q;
  assign age_o  = age_q;
  assign lat_o  = lat_q;
endmodule

module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_STAGES = 3,
  parameter int LAT_W      = 2,
  parameter int FSEL_W     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic                  id_wreg,
  input  logic [REG_ADDR_W-1:0] id_wdst,
  input  logic [LAT_W-1:0]      id_lat,
  input  logic                  id_branch_taken,
  input  logic                  ex_busy,
  output logic                  stall,
  output logic                  issue,
  output logic [FSEL_W-1:0]     fwda,
  output logic [FSEL_W-1:0]     fwdb,
  output logic                  redirect,
  output logic                  cancel_next,
  output logic [15:0]           stall_cycles
);
  localparam int              NREGS = 2 ** REG_ADDR_W;
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(FWD_STAGES);

  logic [NREGS-1:0]             pend_v, ins_v;
  logic [NREGS-1:0][FSEL_W-1:0] age_v, lat_v;
  logic [LAT_W-1:0]             eff_lat;
  logic                         cancel_q;
  logic                         active, a_pend, b_pend, a_haz, b_haz, ins_en;

  // out-of-range latency (0 or beyond the last forward stage) means "last stage"
  assign eff_lat = (id_lat == '0 || id_lat > LAT_MAX) ? LAT_MAX : id_lat;
  assign ins_en  = issue & id_wreg & (id_wdst != '0);

  genvar i;
  generate
    for (i = 0; i < NREGS; i++) begin : g_ent
      if (i == 0) begin : g_r0
        assign ins_v[i] = 1'b0;  // r0 is hard-wired, never tracked
      end else begin : g_rn
        assign ins_v[i] = ins_en & (id_wdst == REG_ADDR_W'(i));
      end
      hazard_sb_entry #(.FWD_STAGES(FWD_STAGES), .FSEL_W(FSEL_W)) u_ent (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold_i    (ex_busy),
        .ins_i     (ins_v[i]),
        .ins_lat_i (FSEL_W'(eff_lat)),
        .pend_o    (pend_v[i]),
        .age_o     (age_v[i]),
        .lat_o     (lat_v[i])
      );
    end
  endgenerate

  // Operand lookup: a pending producer not yet at its forwardable stage is a
  // hazard; otherwise forward from the stage it currently occupies.
  assign a_pend = id_rs_used & (id_rs != '0) & pend_v[id_rs];
  assign b_pend = id_rt_used & (id_rt != '0) & pend_v[id_rt];
  assign a_haz  = a_pend & (age_v[id_rs] < lat_v[id_rs]);
  assign b_haz  = b_pend & (age_v[id_rt] < lat_v[id_rt]);
  assign fwda   = (a_pend & ~a_haz) ? age_v[id_rs] : '0;
  assign fwdb   = (b_pend & ~b_haz) ? age_v[id_rt] : '0;

  // a squashed slot is a bubble: it neither stalls nor issues
  assign active   = id_valid & ~cancel_q;
  assign stall    = active & (a_haz | b_haz | ex_busy);
  assign issue    = active & ~stall;
  assign redirect = issue & id_branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cancel_q <= 1'b0;
    else        cancel_q <= redirect;
  end
  assign cancel_next = cancel_q;

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end
  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
  logic       clk, rst_n;
  logic       id_valid, id_rs_used, id_rt_used, id_wreg, id_branch_taken, ex_busy;
  logic [4:0] id_rs, id_rt, id_wdst;
  logic [1:0] id_lat;
  logic       stall, issue, redirect, cancel_next;
  logic [1:0] fwda, fwdb;
  logic [15:0] stall_cycles;

  int nchk = 0;
  int nfail = 0;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wreg(id_wreg),
    .id_wdst(id_wdst), .id_lat(id_lat), .id_branch_taken(id_branch_taken),
    .ex_busy(ex_busy), .stall(stall), .issue(issue), .fwda(fwda), .fwdb(fwdb),
    .redirect(redirect), .cancel_next(cancel_next), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic id(input logic v, input logic [4:0] rs, input logic rsu,
                    input logic [4:0] rt, input logic rtu, input logic w,
                    input logic [4:0] wd, input logic [1:0] lat, input logic br);
    id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_wreg = w; id_wdst = wd; id_lat = lat; id_branch_taken = br;
  endtask

  task automatic idle();
    id(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // compare {stall, issue, fwda, fwdb, redirect, cancel_next} now
  task automatic cmp(input string tag, input logic est, input logic eis,
                     input logic [1:0] efa, input logic [1:0] efb,
                     input logic erd, input logic ecn);
    logic [7:0] obs, expv;
    obs  = {stall, issue, fwda, fwdb, redirect, cancel_next};
    expv = {est, eis, efa, efb, erd, ecn};
    nchk++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: st/is/fa/fb/rd/cn got %b want %b", tag, obs, expv);
    end
  endtask

  task automatic chk(input string tag, input logic est, input logic eis,
                     input logic [1:0] efa, input logic [1:0] efb,
                     input logic erd, input logic ecn);
    @(negedge clk);
    cmp(tag, est, eis, efa, efb, erd, ecn);
  endtask

  task automatic cmp_cnt(input string tag, input logic [15:0] e);
    nchk++;
    assert (stall_cycles === e) else begin
      nfail++;
      $error("FAIL %s: stall_cycles got %0d want %0d", tag, stall_cycles, e);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ex_busy = 1'b0;
    idle();
    #12;
    cmp("reset", 0, 0, 0, 0, 0, 0);
    cmp_cnt("reset_cnt", 16'd0);
    rst_n = 1'b1;
    adv();

    // ALU producer r3, consumer forwards from EXE
    id(1, 0, 0, 0, 0, 1, 3, 1, 0); chk("add_r3", 0, 1, 0, 0, 0, 0); adv();
    id(1, 3, 1, 0, 0, 0, 0, 0, 0); chk("use_r3", 0, 1, 1, 0, 0, 0); adv();

    // load r4, one-cycle load-use stall then forward from stage 2
    id(1, 0, 0, 0, 0, 1, 4, 2, 0); chk("lw_r4", 0, 1, 0, 0, 0, 0); adv();
    id(1, 0, 0, 4, 1, 0, 0, 0, 0); chk("use_r4_stall", 1, 0, 0, 0, 0, 0); adv();
    chk("use_r4_fwd", 0, 1, 0, 2, 0, 0);
    cmp_cnt("cnt_after_lw", PERF ? 16'd1 : 16'd0);
    adv();

    // r5 forwarded from last stage at N=3, from register file at N=4
    id(1, 0, 0, 0, 0, 1, 5, 1, 0); chk("prod_r5", 0, 1, 0, 0, 0, 0); adv();
    idle(); adv();
    adv();
    id(1, 5, 1, 0, 0, 0, 0, 0, 0); chk("use_r5_n3", 0, 1, 3, 0, 0, 0); adv();
    chk("use_r5_n4", 0, 1, 0, 0, 0, 0); adv();

    // WAW: ADDI r6 replaces LW r6
    id(1, 0, 0, 0, 0, 1, 6, 2, 0); chk("lw_r6", 0, 1, 0, 0, 0, 0); adv();
    id(1, 0, 0, 0, 0, 1, 6, 1, 0); chk("addi_r6", 0, 1, 0, 0, 0, 0); adv();
    id(1, 6, 1, 0, 0, 0, 0, 0, 0); chk("use_r6", 0, 1, 1, 0, 0, 0); adv();

    // writes to r0 are never tracked
    id(1, 0, 0, 0, 0, 1, 0, 2, 0); chk("wr_r0", 0, 1, 0, 0, 0, 0); adv();
    id(1, 0, 1, 0, 1, 0, 0, 0, 0); chk("use_r0", 0, 1, 0, 0, 0, 0); adv();

    // latency 0 clamps to 3; a branch during the stall is ignored
    id(1, 0, 0, 0, 0, 1, 8, 0, 0); chk("lat0_r8", 0, 1, 0, 0, 0, 0); adv();
    id(1, 8, 1, 0, 0, 0, 0, 0, 1); chk("r8_stall1_br", 1, 0, 0, 0, 0, 0); adv();
    chk("r8_stall2", 1, 0, 0, 0, 0, 0); adv();
    chk("r8_fwd3", 0, 1, 3, 0, 1, 0); adv();
    // previous cycle's redirect sets cancel_next; slot below is a bubble
    idle(); chk("cancel_after_br", 0, 0, 0, 0, 0, 1); adv();

    // taken branch, then squashed slot with a hazard on r4
    id(1, 0, 0, 0, 0, 1, 4, 3, 0); chk("lw_r4_l3", 0, 1, 0, 0, 0, 0); adv();
    id(1, 0, 0, 0, 0, 0, 0, 0, 1); chk("branch", 0, 1, 0, 0, 1, 0); adv();
    id(1, 0, 0, 4, 1, 1, 9, 1, 0); chk("cancel_slot", 0, 0, 0, 0, 0, 1); adv();
    id(1, 9, 1, 4, 1, 0, 0, 0, 0); chk("after_cancel", 0, 1, 0, 3, 0, 0); adv();

    // ex_busy freezes aging of LW r7
    id(1, 0, 0, 0, 0, 1, 7, 2, 0); chk("lw_r7", 0, 1, 0, 0, 0, 0); adv();
    ex_busy = 1'b1;
    id(1, 7, 1, 0, 0, 0, 0, 0, 0); chk("busy1", 1, 0, 0, 0, 0, 0); adv();
    chk("busy2", 1, 0, 0, 0, 0, 0); adv();
    ex_busy = 1'b0;
    chk("r7_frozen", 1, 0, 0, 0, 0, 0); adv();
    chk("r7_fwd", 0, 1, 2, 0, 0, 0);
    cmp_cnt("cnt_after_busy", PERF ? 16'd6 : 16'd0);
    adv();

    // async reset during a load-use stall
    id(1, 0, 0, 0, 0, 1, 10, 2, 0); chk("lw_r10", 0, 1, 0, 0, 0, 0); adv();
    id(1, 10, 1, 0, 0, 0, 0, 0, 0); chk("r10_stall", 1, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1 cmp("rst_mid_stall", 0, 1, 0, 0, 0, 0);
    cmp_cnt("rst_cnt", 16'd0);
    adv();
    #3 rst_n = 1'b1;
    chk("post_rst", 0, 1, 0, 0, 0, 0); adv();
    idle(); chk("idle_end", 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard, forwarding and flush controller for the in-order pipeline's decode (ID) stage. It tracks every in-flight register write in a per-register scoreboard. Each producer carries its own result latency, so multi-cycle units (loads, multipliers) are handled without per-opcode special cases. The block drives the decode-stage operand forwarding selects, the pipeline stall, and the one-cycle squash that follows a taken branch.

## Interface
- `REG_ADDR_W`, 5: register address width; scoreboard holds 2^REG_ADDR_W entries, entry 0 never tracked.
- `FWD_STAGES`, 3: number of downstream stages with a forward path (stage 1 = EXE).
- `LAT_W`, 2: width of the latency field; must satisfy 2^LAT_W > FWD_STAGES.
- `FSEL_W`, 2: forward-select width; must satisfy 2^FSEL_W > FWD_STAGES.

Ports. Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `id_valid` in 1: ID holds an instruction.
- `id_rs`, `id_rt` in REG_ADDR_W: source registers.
- `id_rs_used`, `id_rt_used` in 1: source actually read.
- `id_wreg` in 1: instruction writes a register.
- `id_wdst` in REG_ADDR_W: destination register.
- `id_lat` in LAT_W: stage index at which the result becomes forwardable (1 = ALU, 2 = load, ...).
- `id_branch_taken` in 1: branch or jump resolved taken in ID.
- `ex_busy` in 1: downstream structural stall; freezes the pipeline.
- `stall` out 1: hold PC and IF/ID.
- `issue` out 1: ID instruction advances this cycle.
- `fwda`, `fwdb` out FSEL_W: 0 = register file, k = result of stage k.
- `redirect` out 1: taken branch accepted; PC loads target.
- `cancel_next` out 1: squash the instruction currently in IF/ID.
- `stall_cycles` out 16: stall performance counter.

## Operation
- Scoreboard entry per register: `pending`, `age` (0..FWD_STAGES), `lat`.
- Active ID instruction: `id_valid & !cancel_next`.
- Effective latency: `id_lat` clamped to 1..FWD_STAGES; a value of 0 or greater than FWD_STAGES is treated as FWD_STAGES.
- Operand check, per used source with nonzero address and `pending` set; current stage s = `age`:
  - s >= `lat`: no hazard, select = s.
  - s < `lat`: data hazard, select = 0.
- A source that is not pending, unused, or register 0 gets select 0.
- `stall` = active & (data hazard on either operand | `ex_busy`).
- `issue` = active & !`stall`.
- `redirect` = `issue` & `id_branch_taken`. A branch is ignored while stalled.
- Scoreboard update at the clock edge when `ex_busy` = 0:
  - Every pending entry does `age += 1`.
  - An entry whose age would exceed FWD_STAGES clears `pending` (retired to the register file; the register file is write-through).
- Scoreboard update when `ex_busy` = 1: all entries hold.
- On `issue & id_wreg & id_wdst != 0`: entry `id_wdst` is overwritten with pending = 1, age = 1, lat = effective latency.
  - WAW: the youngest producer replaces the older one. This is correct because clamped latencies keep writeback in order.
  - Overwrite takes priority over aging of the same entry.
- `cancel_next` is registered: next value = `redirect`. While it is 1, the ID instruction is a bubble: no issue, no stall, no scoreboard insert.
- Reset: all `pending` cleared, `cancel_next` = 0, `stall_cycles` = 0. Consequently `stall`, `issue`, `redirect` = 0 and `fwda`, `fwdb` = 0 whenever inputs are idle.

## Timing
- `stall`, `issue`, `redirect`, `fwda`, `fwdb`: combinational from ID inputs and scoreboard state, same cycle.
- Scoreboard update and `cancel_next`: one clock after the causing event.
- A consumer issued N cycles after a producer with latency L:
  - Stalls for max(0, L−N) cycles.
  - Then forwards from stage max(N, L).
  - Reads the register file once N > FWD_STAGES.
- Asserting `rst_n` mid-stall clears state asynchronously. `stall` falls without waiting for a clock.

## Configuration
- `HAZARD_PERF_EN` defined: `stall_cycles` increments each cycle `stall` = 1 and saturates at 0xFFFF.
- `HAZARD_PERF_EN` undefined: counter logic is omitted and `stall_cycles` is tied to 0.

## Test plan
- ADD r3 (lat 1) issues; next cycle a consumer with rs = 3 -> `stall` = 0, `fwda` = 1, `issue` = 1.
- LW r4 (lat 2); next-cycle consumer with rt = 4 -> `stall` = 1 for one cycle, then `fwdb` = 2, `issue` = 1; with `HAZARD_PERF_EN`, `stall_cycles` = 1.
- Producer r5 (lat 1); consumers issued 3 and 4 cycles later -> `fwda` = 3, then `fwda` = 0 with r5 no longer pending.
- LW r6 (lat 2) followed immediately by ADDI r6 (lat 1); consumer of r6 next cycle -> `fwda` = 1, `stall` = 0.
- Taken branch issues -> `redirect` = 1. Next cycle `cancel_next` = 1 while ID presents a hazard on r4 -> `stall` = 0, `issue` = 0, scoreboard unchanged.
- `ex_busy` held 2 cycles after LW r7 -> ages frozen; consumer stalls until 2 clear cycles elapse. `rst_n` low during the stall -> `stall` = 0 immediately, all entries cleared.
